// File: rtl/map_table_ctrl.sv
// map_table_ctrl
//   Sequencer/arbiter in front of phys_reg_map_table. Each cycle it picks at most
//   one map-table op with priority revert > restore > save > rename. It counts live
//   checkpoints, stalls branch dispatch when no column is free, blocks dispatch
//   during ROB revert walks, and blocks it for one flush cycle after a mispredict
//   restore.
//
// Ports
//   CLK, nRST                     clock, synchronous active-low reset
//   disp_*                        dispatch request (valid, branch, writes_reg, ROB index, rename pair)
//   disp_ready                    dispatch op accepted this cycle (combinational)
//   resolve_*                     branch resolve (valid, mispredict, ROB index, safe column)
//   resolve_ack                   restore accepted by the map table (combinational)
//   rob_revert_*                  ROB walk reverting one instruction this cycle
//   mt_*                          op valids + fields to the map table; at most one valid per cycle
//   mt_save/restore_checkpoint_success  map-table success returns
//   flush_pulse                   one-cycle front-end flush after a mispredict restore
//   live_checkpoints, ckpt_full   outstanding checkpoint count, full flag
//
// Configuration
//   MAP_TABLE_CTRL_PERF_EN  adds saturating 32-bit counters perf_stall_full_cycles,
//                           perf_stall_revert_cycles and perf_mispredicts.
module map_table_ctrl #(
    parameter int CHECKPOINT_COLUMNS = 4,
    parameter int CNT_W  = $clog2(CHECKPOINT_COLUMNS) + 1,
    parameter int COL_W  = $clog2(CHECKPOINT_COLUMNS),
    parameter int ROB_W  = 6,
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6
) (
    input  logic              CLK,
    input  logic              nRST,
    // dispatch
    input  logic              disp_valid,
    input  logic              disp_is_branch,
    input  logic              disp_writes_reg,
    input  logic [ROB_W-1:0]  disp_ROB_index,
    input  logic [ARCH_W-1:0] disp_dest_arch,
    input  logic [PHYS_W-1:0] disp_dest_phys,
    output logic              disp_ready,
    // branch resolve
    input  logic              resolve_valid,
    input  logic              resolve_mispredict,
    input  logic [ROB_W-1:0]  resolve_ROB_index,
    input  logic [COL_W-1:0]  resolve_safe_column,
    output logic              resolve_ack,
    // ROB revert walk
    input  logic              rob_revert_valid,
    input  logic [ARCH_W-1:0] rob_revert_arch,
    input  logic [PHYS_W-1:0] rob_revert_safe_phys,
    input  logic [PHYS_W-1:0] rob_revert_spec_phys,
    // map table interface
    output logic              mt_rename_valid,
    output logic [ARCH_W-1:0] mt_rename_arch,
    output logic [PHYS_W-1:0] mt_rename_phys,
    output logic              mt_revert_valid,
    output logic [ARCH_W-1:0] mt_revert_arch,
    output logic [PHYS_W-1:0] mt_revert_safe_phys,
    output logic [PHYS_W-1:0] mt_revert_spec_phys,
    output logic              mt_save_checkpoint_valid,
    output logic [ROB_W-1:0]  mt_save_checkpoint_ROB_index,
    input  logic              mt_save_checkpoint_success,
    output logic              mt_restore_checkpoint_valid,
    output logic              mt_restore_checkpoint_speculate_failed,
    output logic [ROB_W-1:0]  mt_restore_checkpoint_ROB_index,
    output logic [COL_W-1:0]  mt_restore_checkpoint_safe_column,
    input  logic              mt_restore_checkpoint_success,
    // status
    output logic              flush_pulse,
    output logic [CNT_W-1:0]  live_checkpoints,
    output logic              ckpt_full
`ifdef MAP_TABLE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_full_cycles,
    output logic [31:0]       perf_stall_revert_cycles,
    output logic [31:0]       perf_mispredicts
`endif
);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_REVERT = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [CNT_W-1:0] LIVE_MAX = CNT_W'(CHECKPOINT_COLUMNS - 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] live_q;
    // branch that also writes a reg: its checkpoint is taken, rename still owed
    logic             pending;
    logic             sel_rename, sel_revert, sel_save, sel_restore;

    assign live_checkpoints = live_q;
    assign ckpt_full        = (live_q == LIVE_MAX);

    always_comb begin
        state_n     = state;
        sel_rename  = 1'b0;
        sel_revert  = 1'b0;
        sel_save    = 1'b0;
        sel_restore = 1'b0;
        disp_ready  = 1'b0;
        resolve_ack = 1'b0;
        flush_pulse = 1'b0;
        if (nRST) begin
            case (state)
                ST_FLUSH: begin
                    flush_pulse = 1'b1;
                    state_n     = ST_NORMAL;
                end
                ST_REVERT: begin
                    if (rob_revert_valid) sel_revert = 1'b1;
                    else                  state_n    = ST_NORMAL;
                end
                default: begin
                    if (rob_revert_valid) begin
                        sel_revert = 1'b1;
                        state_n    = ST_REVERT;
                    end else if (resolve_valid) begin
                        // a failed restore leaves the resolver holding its request
                        sel_restore = 1'b1;
                        resolve_ack = mt_restore_checkpoint_success;
                        if (mt_restore_checkpoint_success && resolve_mispredict)
                            state_n = ST_FLUSH;
                    end else if (disp_valid) begin
                        if (disp_is_branch && !pending) begin
                            if (!ckpt_full) begin
                                sel_save   = 1'b1;
                                // a reg-writing branch still needs its rename next
                                disp_ready = mt_save_checkpoint_success && !disp_writes_reg;
                            end
                        end else if (disp_writes_reg) begin
                            sel_rename = 1'b1;
                            disp_ready = 1'b1;
                        end else begin
                            disp_ready = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // fields are zeroed when their op is not selected
    assign mt_rename_valid                        = sel_rename;
    assign mt_rename_arch                         = sel_rename ? disp_dest_arch : '0;
    assign mt_rename_phys                         = sel_rename ? disp_dest_phys : '0;
    assign mt_revert_valid                        = sel_revert;
    assign mt_revert_arch                         = sel_revert ? rob_revert_arch : '0;
    assign mt_revert_safe_phys                    = sel_revert ? rob_revert_safe_phys : '0;
    assign mt_revert_spec_phys                    = sel_revert ? rob_revert_spec_phys : '0;
    assign mt_save_checkpoint_valid               = sel_save;
    assign mt_save_checkpoint_ROB_index           = sel_save ? disp_ROB_index : '0;
    assign mt_restore_checkpoint_valid            = sel_restore;
    assign mt_restore_checkpoint_speculate_failed = sel_restore & resolve_mispredict;
    assign mt_restore_checkpoint_ROB_index        = sel_restore ? resolve_ROB_index : '0;
    assign mt_restore_checkpoint_safe_column      = sel_restore ? resolve_safe_column : '0;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= ST_NORMAL;
            live_q  <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_n;
            if (sel_restore && mt_restore_checkpoint_success) begin
                if (resolve_mispredict) begin
                    // mispredict squashes every younger checkpoint and the front end
                    live_q  <= '0;
                    pending <= 1'b0;
                end else begin
                    assert (live_q != '0)
                        else $error("map_table_ctrl: live checkpoint counter underflow");
                    if (live_q != '0) live_q <= live_q - 1'b1;
                end
            end else if (sel_save && mt_save_checkpoint_success) begin
                live_q  <= live_q + 1'b1;
                pending <= disp_writes_reg;
            end else if (disp_ready) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef MAP_TABLE_CTRL_PERF_EN
    logic stall_full;
    assign stall_full = nRST && (state == ST_NORMAL) && !rob_revert_valid && !resolve_valid &&
                        disp_valid && disp_is_branch && !pending && ckpt_full;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_stall_full_cycles   <= '0;
            perf_stall_revert_cycles <= '0;
            perf_mispredicts         <= '0;
        end else begin
            if (stall_full && perf_stall_full_cycles != '1)
                perf_stall_full_cycles <= perf_stall_full_cycles + 32'd1;
            if (state == ST_REVERT && perf_stall_revert_cycles != '1)
                perf_stall_revert_cycles <= perf_stall_revert_cycles + 32'd1;
            if (sel_restore && mt_restore_checkpoint_success && resolve_mispredict &&
                perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_map_table_ctrl.sv
module tb_map_table_ctrl;
    localparam int CC = 4, CNT_W = 3, COL_W = 2, ROB_W = 6, ARCH_W = 5, PHYS_W = 6;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic nRST;
    logic disp_valid, disp_is_branch, disp_writes_reg, disp_ready;
    logic [ROB_W-1:0] disp_ROB_index;
    logic [ARCH_W-1:0] disp_dest_arch;
    logic [PHYS_W-1:0] disp_dest_phys;
    logic resolve_valid, resolve_mispredict, resolve_ack;
    logic [ROB_W-1:0] resolve_ROB_index;
    logic [COL_W-1:0] resolve_safe_column;
    logic rob_revert_valid;
    logic [ARCH_W-1:0] rob_revert_arch;
    logic [PHYS_W-1:0] rob_revert_safe_phys, rob_revert_spec_phys;
    logic mt_rename_valid, mt_revert_valid, mt_save_checkpoint_valid, mt_restore_checkpoint_valid;
    logic [ARCH_W-1:0] mt_rename_arch, mt_revert_arch;
    logic [PHYS_W-1:0] mt_rename_phys, mt_revert_safe_phys, mt_revert_spec_phys;
    logic [ROB_W-1:0] mt_save_checkpoint_ROB_index, mt_restore_checkpoint_ROB_index;
    logic mt_restore_checkpoint_speculate_failed;
    logic [COL_W-1:0] mt_restore_checkpoint_safe_column;
    logic mt_save_checkpoint_success, mt_restore_checkpoint_success;
    logic flush_pulse, ckpt_full;
    logic [CNT_W-1:0] live_checkpoints;
`ifdef MAP_TABLE_CTRL_PERF_EN
    logic [31:0] perf_stall_full_cycles, perf_stall_revert_cycles, perf_mispredicts;
`endif

    map_table_ctrl #(.CHECKPOINT_COLUMNS(CC)) dut (
        .CLK(CLK), .nRST(nRST),
        .disp_valid(disp_valid), .disp_is_branch(disp_is_branch), .disp_writes_reg(disp_writes_reg),
        .disp_ROB_index(disp_ROB_index), .disp_dest_arch(disp_dest_arch), .disp_dest_phys(disp_dest_phys),
        .disp_ready(disp_ready),
        .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
        .resolve_ROB_index(resolve_ROB_index), .resolve_safe_column(resolve_safe_column),
        .resolve_ack(resolve_ack),
        .rob_revert_valid(rob_revert_valid), .rob_revert_arch(rob_revert_arch),
        .rob_revert_safe_phys(rob_revert_safe_phys), .rob_revert_spec_phys(rob_revert_spec_phys),
        .mt_rename_valid(mt_rename_valid), .mt_rename_arch(mt_rename_arch), .mt_rename_phys(mt_rename_phys),
        .mt_revert_valid(mt_revert_valid), .mt_revert_arch(mt_revert_arch),
        .mt_revert_safe_phys(mt_revert_safe_phys), .mt_revert_spec_phys(mt_revert_spec_phys),
        .mt_save_checkpoint_valid(mt_save_checkpoint_valid),
        .mt_save_checkpoint_ROB_index(mt_save_checkpoint_ROB_index),
        .mt_save_checkpoint_success(mt_save_checkpoint_success),
        .mt_restore_checkpoint_valid(mt_restore_checkpoint_valid),
        .mt_restore_checkpoint_speculate_failed(mt_restore_checkpoint_speculate_failed),
        .mt_restore_checkpoint_ROB_index(mt_restore_checkpoint_ROB_index),
        .mt_restore_checkpoint_safe_column(mt_restore_checkpoint_safe_column),
        .mt_restore_checkpoint_success(mt_restore_checkpoint_success),
        .flush_pulse(flush_pulse), .live_checkpoints(live_checkpoints), .ckpt_full(ckpt_full)
`ifdef MAP_TABLE_CTRL_PERF_EN
        ,
        .perf_stall_full_cycles(perf_stall_full_cycles),
        .perf_stall_revert_cycles(perf_stall_revert_cycles),
        .perf_mispredicts(perf_mispredicts)
`endif
    );

    typedef struct packed {
        logic ready, ack, flush;
        logic ren_v; logic [ARCH_W-1:0] ren_arch; logic [PHYS_W-1:0] ren_phys;
        logic rev_v; logic [ARCH_W-1:0] rev_arch; logic [PHYS_W-1:0] rev_safe, rev_spec;
        logic sav_v; logic [ROB_W-1:0] sav_rob;
        logic rst_v, rst_fail; logic [ROB_W-1:0] rst_rob; logic [COL_W-1:0] rst_col;
        logic [CNT_W-1:0] live; logic full;
    } obs_t;

    obs_t obs;
    assign obs = {disp_ready, resolve_ack, flush_pulse,
                  mt_rename_valid, mt_rename_arch, mt_rename_phys,
                  mt_revert_valid, mt_revert_arch, mt_revert_safe_phys, mt_revert_spec_phys,
                  mt_save_checkpoint_valid, mt_save_checkpoint_ROB_index,
                  mt_restore_checkpoint_valid, mt_restore_checkpoint_speculate_failed,
                  mt_restore_checkpoint_ROB_index, mt_restore_checkpoint_safe_column,
                  live_checkpoints, ckpt_full};

    int total = 0, bad = 0;
    obs_t o_q, e_q;

    // reference model: checkpoint count, owed rename, walk in progress, flush owed
    int m_live = 0;
    bit m_pending = 0, m_walk = 0, m_flush = 0;

    function automatic obs_t model_eval();
        obs_t e = '0;
        e.live = CNT_W'(m_live);
        e.full = (m_live == CC - 1);
        if (!nRST) return e;
        if (m_flush) begin
            e.flush = 1'b1;
        end else if (m_walk || rob_revert_valid) begin
            if (rob_revert_valid) begin
                e.rev_v = 1'b1; e.rev_arch = rob_revert_arch;
                e.rev_safe = rob_revert_safe_phys; e.rev_spec = rob_revert_spec_phys;
            end
        end else if (resolve_valid) begin
            e.rst_v = 1'b1; e.rst_fail = resolve_mispredict;
            e.rst_rob = resolve_ROB_index; e.rst_col = resolve_safe_column;
            e.ack = mt_restore_checkpoint_success;
        end else if (disp_valid) begin
            if (disp_is_branch && !m_pending) begin
                if (m_live < CC - 1) begin
                    e.sav_v = 1'b1; e.sav_rob = disp_ROB_index;
                    e.ready = mt_save_checkpoint_success && !disp_writes_reg;
                end
            end else begin
                e.ready = 1'b1;
                if (disp_writes_reg) begin
                    e.ren_v = 1'b1; e.ren_arch = disp_dest_arch; e.ren_phys = disp_dest_phys;
                end
            end
        end
        return e;
    endfunction

    function automatic void model_commit();
        if (!nRST) begin m_live = 0; m_pending = 0; m_walk = 0; m_flush = 0; return; end
        if (m_flush) begin m_flush = 0; return; end
        if (m_walk) begin if (!rob_revert_valid) m_walk = 0; return; end
        if (rob_revert_valid) begin m_walk = 1; return; end
        if (resolve_valid) begin
            if (mt_restore_checkpoint_success) begin
                if (resolve_mispredict) begin m_live = 0; m_pending = 0; m_flush = 1; end
                else if (m_live > 0) m_live--;
            end
            return;
        end
        if (disp_valid) begin
            if (disp_is_branch && !m_pending) begin
                if (m_live < CC - 1 && mt_save_checkpoint_success) begin
                    m_live++; m_pending = disp_writes_reg;
                end
            end else m_pending = 0;
        end
    endfunction

    task automatic idle();
        nRST = 1'b1;
        disp_valid = 0; disp_is_branch = 0; disp_writes_reg = 0;
        disp_ROB_index = 0; disp_dest_arch = 0; disp_dest_phys = 0;
        resolve_valid = 0; resolve_mispredict = 0; resolve_ROB_index = 0; resolve_safe_column = 0;
        rob_revert_valid = 0; rob_revert_arch = 0; rob_revert_safe_phys = 0; rob_revert_spec_phys = 0;
        mt_save_checkpoint_success = 1; mt_restore_checkpoint_success = 1;
    endtask

    // capture outputs mid-cycle, then advance model and clock
    task automatic tick();
        @(negedge CLK);
        e_q = model_eval();
        o_q = obs;
        model_commit();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        idle(); nRST = 0; disp_valid = 1; disp_writes_reg = 1; disp_dest_arch = 5'd3;
        tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL reset_model obs=%h exp=%h", o_q, e_q); end
        total++; if ({o_q.ready, o_q.ren_v, o_q.live, o_q.full} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs ready=%b ren=%b live=%0d full=%b", o_q.ready, o_q.ren_v, o_q.live, o_q.full); end
        idle(); disp_valid = 1; disp_writes_reg = 1;
        tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL reset_release obs=%h exp=%h", o_q, e_q); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) begin
            idle(); disp_valid = 1; disp_is_branch = 1; disp_ROB_index = 6'(i + 1);
            tick();
            total++; if (o_q !== e_q) begin bad++; $display("FAIL fill_%0d obs=%h exp=%h", i, o_q, e_q); end
            total++; if ({o_q.sav_v, o_q.ready, o_q.live} !== {2'b11, 3'(i)}) begin
                bad++; $display("FAIL fill_save_%0d sav=%b ready=%b live=%0d", i, o_q.sav_v, o_q.ready, o_q.live); end
        end
        idle(); disp_valid = 1; disp_is_branch = 1; disp_ROB_index = 6'd4;
        tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL fill_full obs=%h exp=%h", o_q, e_q); end
        total++; if ({o_q.live, o_q.full, o_q.ready, o_q.sav_v} !== {3'd3, 3'b100}) begin
            bad++; $display("FAIL fill_stall live=%0d full=%b ready=%b sav=%b", o_q.live, o_q.full, o_q.ready, o_q.sav_v); end
    endtask

    task automatic test_correct_resolve();
        idle(); resolve_valid = 1; resolve_ROB_index = 6'd5; resolve_safe_column = 2'd1;
        tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL correct_model obs=%h exp=%h", o_q, e_q); end
        total++; if ({o_q.rst_v, o_q.rst_fail, o_q.rst_rob, o_q.rst_col, o_q.ack} !== {2'b10, 6'd5, 2'd1, 1'b1}) begin
            bad++; $display("FAIL correct_restore v=%b fail=%b rob=%0d col=%0d ack=%b",
                            o_q.rst_v, o_q.rst_fail, o_q.rst_rob, o_q.rst_col, o_q.ack); end
        idle(); tick();
        total++; if ({o_q.live, o_q.full} !== {3'd2, 1'b0}) begin
            bad++; $display("FAIL correct_live live=%0d full=%b want 2/0", o_q.live, o_q.full); end
    endtask

    task automatic test_mispredict();
        idle(); resolve_valid = 1; resolve_mispredict = 1; resolve_ROB_index = 6'd7;
        tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL mispred_model obs=%h exp=%h", o_q, e_q); end
        for (int i = 0; i < 2; i++) begin
            idle(); disp_valid = 1; disp_writes_reg = 1; disp_dest_arch = 5'd9; disp_dest_phys = 6'd33;
            tick();
            total++; if (o_q !== e_q) begin bad++; $display("FAIL mispred_cyc%0d obs=%h exp=%h", i, o_q, e_q); end
            total++; if ({o_q.flush, o_q.ready, o_q.live} !== {(i == 0), (i != 0), 3'd0}) begin
                bad++; $display("FAIL mispred_flush%0d flush=%b ready=%b live=%0d", i, o_q.flush, o_q.ready, o_q.live); end
        end
    endtask

    task automatic test_revert();
        for (int i = 0; i < 5; i++) begin
            idle(); disp_valid = 1; disp_writes_reg = 1;
            rob_revert_valid = (i < 3);
            rob_revert_arch = 5'($urandom); rob_revert_safe_phys = 6'($urandom); rob_revert_spec_phys = 6'($urandom);
            tick();
            total++; if (o_q !== e_q) begin bad++; $display("FAIL revert_cyc%0d obs=%h exp=%h", i, o_q, e_q); end
            total++; if ({o_q.rev_v, o_q.ready} !== {(i < 3), (i == 4)}) begin
                bad++; $display("FAIL revert_seq%0d rev=%b ready=%b", i, o_q.rev_v, o_q.ready); end
        end
    endtask

    task automatic test_resolve_vs_save();
        idle(); disp_valid = 1; disp_is_branch = 1; disp_ROB_index = 6'd10;
        tick();
        idle(); disp_valid = 1; disp_is_branch = 1; disp_ROB_index = 6'd11;
        resolve_valid = 1; resolve_ROB_index = 6'd10; resolve_safe_column = 2'd2;
        tick();
        total++; if ({o_q.rst_v, o_q.sav_v, o_q.ready} !== 3'b100) begin
            bad++; $display("FAIL rvs_same rst=%b sav=%b ready=%b", o_q.rst_v, o_q.sav_v, o_q.ready); end
        idle(); disp_valid = 1; disp_is_branch = 1; disp_ROB_index = 6'd11;
        tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL rvs_retry obs=%h exp=%h", o_q, e_q); end
        total++; if ({o_q.sav_v, o_q.sav_rob, o_q.ready} !== {1'b1, 6'd11, 1'b1}) begin
            bad++; $display("FAIL rvs_save sav=%b rob=%0d ready=%b", o_q.sav_v, o_q.sav_rob, o_q.ready); end
    endtask

    task automatic test_restore_fail();
        idle(); resolve_valid = 1; resolve_mispredict = 1; resolve_ROB_index = 6'd12;
        mt_restore_checkpoint_success = 0;
        tick();
        total++; if ({o_q.rst_v, o_q.ack} !== 2'b10) begin
            bad++; $display("FAIL rfail_ack rst=%b ack=%b", o_q.rst_v, o_q.ack); end
        idle(); tick();
        total++; if ({o_q.flush, o_q.live} !== {1'b0, 3'd1}) begin
            bad++; $display("FAIL rfail_hold flush=%b live=%0d want 0/1", o_q.flush, o_q.live); end
    endtask

    task automatic test_branch_rename();
        for (int i = 0; i < 2; i++) begin
            idle(); disp_valid = 1; disp_is_branch = 1; disp_writes_reg = 1;
            disp_ROB_index = 6'd9; disp_dest_arch = 5'd4; disp_dest_phys = 6'd40;
            tick();
            total++; if (o_q !== e_q) begin bad++; $display("FAIL brren_cyc%0d obs=%h exp=%h", i, o_q, e_q); end
            total++; if ({o_q.sav_v, o_q.ren_v, o_q.ready} !== {(i == 0), (i == 1), (i == 1)}) begin
                bad++; $display("FAIL brren_seq%0d sav=%b ren=%b ready=%b", i, o_q.sav_v, o_q.ren_v, o_q.ready); end
        end
    endtask

    task automatic test_midop_reset();
        idle(); rob_revert_valid = 1; tick();
        idle(); nRST = 0; tick();
        total++; if (o_q !== e_q) begin bad++; $display("FAIL midrst_hold obs=%h exp=%h", o_q, e_q); end
        idle(); disp_valid = 1; tick();
        total++; if ({o_q.ready, o_q.live} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL midrst_clear ready=%b live=%0d", o_q.ready, o_q.live); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            idle();
            rob_revert_valid = m_walk ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            rob_revert_arch = 5'($urandom); rob_revert_safe_phys = 6'($urandom); rob_revert_spec_phys = 6'($urandom);
            resolve_valid = ($urandom_range(0, 4) == 0);
            resolve_mispredict = ($urandom_range(0, 3) == 0);
            if (resolve_valid && !resolve_mispredict && m_live == 0) resolve_valid = 0;
            resolve_ROB_index = 6'($urandom); resolve_safe_column = 2'($urandom);
            disp_valid = ($urandom_range(0, 3) != 0);
            disp_is_branch = ($urandom_range(0, 2) == 0);
            disp_writes_reg = ($urandom_range(0, 1) == 1);
            disp_ROB_index = 6'($urandom); disp_dest_arch = 5'($urandom); disp_dest_phys = 6'($urandom);
            mt_save_checkpoint_success = ($urandom_range(0, 9) != 0);
            mt_restore_checkpoint_success = ($urandom_range(0, 9) != 0);
            tick();
            total++; if (o_q !== e_q) begin bad++; $display("FAIL random_%0d obs=%h exp=%h", i, o_q, e_q); end
        end
    endtask

    initial begin
        idle(); nRST = 0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_fill();
        test_correct_resolve();
        test_mispredict();
        test_revert();
        test_resolve_vs_save();
        test_restore_fail();
        test_branch_rename();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
